// File: rtl/apb_requester_pkg.sv
// Shared types and constants for the APB requester and its PSEL decoder.
package apb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int SEL_IDX_W = 4;

endpackage

// File: rtl/apb_psel_decode.sv
// Completer index to one-hot PSEL; o_oor flags an index with no completer behind it.
module apb_psel_decode
    import apb_requester_pkg::*;
#(
    parameter int NUM_SLAVES = 16
)(
    input  logic [SEL_IDX_W-1:0]  i_idx,
    output logic [NUM_SLAVES-1:0] o_psel,
    output logic                  o_oor
);

    always_comb begin
        o_psel = '0;
        o_oor  = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i_idx == SEL_IDX_W'(i)) begin
                o_psel[i] = 1'b1;
                o_oor     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_requester.sv
// APB requester: one valid/ready command becomes one SETUP->ACCESS transfer, with
// decode-error and hung-completer timeout reported on a valid/ready response port.
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 16,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 256
)(
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_e                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [CNT_W-1:0]      r_wait_cnt;

    logic [NUM_SLAVES-1:0] w_psel;
    logic                  w_oor;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_tmo;

    apb_psel_decode #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_psel_decode (
        .i_idx  (req_addr[SLV_LSB +: SEL_IDX_W]),
        .o_psel (w_psel),
        .o_oor  (w_oor)
    );

    assign w_accept  = req_valid && r_req_ready;
    assign w_cnt_inc = r_wait_cnt + CNT_W'(1);
    // Abort on the TIMEOUT-th consecutive PREADY-low ACCESS cycle; the counter never wraps.
    assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == TO_VAL);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (w_oor) begin
                            // Decode error: answer straight away without touching the bus.
                            r_state       <= RESP;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_rdata   <= '0;
                        end else begin
                            r_state    <= SETUP;
                            r_psel     <= w_psel;
                            r_paddr    <= req_addr;
                            r_pwdata   <= req_wdata;
                            r_pwrite   <= req_write;
                            r_wait_cnt <= '0;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_state       <= RESP;
                        r_psel        <= '0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
                    end else if (w_tmo) begin
                        r_state       <= RESP;
                        r_psel        <= '0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;

endmodule
